dmem_arbiter: RTL

Shares the single byte-write data-memory BRAM port between NUM_REQ requesters: requester 0 is the riscv_core dmem port, requester 1 is the program loader/debug port. Round-robin arbitration with a valid/ready request handshake. Each accepted request returns a one-cycle response pulse to its owner exactly READ_LATENCY cycles later, matching the HIGH_PERFORMANCE BRAM's 2-cycle read. Sits between the requesters and the BRAM port B.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned OFS_W      = $clog2(WORD_BYTES);
    // Owner id width covers up to four requesters.
    localparam int unsigned ID_W       = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant and the rotating search pointer.
module rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    logic [ID_W-1:0] ptr;
    logic [ID_W:0]   idx;
    logic [ID_W:0]   nxt;

    // Search from the pointer, wrapping, and grant the first valid requester.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && (idx == (ID_W+1)'(i)) && valid[i]) begin
                    grant[i]  = 1'b1;
                    grant_id  = ID_W'(i);
                    grant_any = 1'b1;
                end
            end
        end
    end

    // Pointer moves to the requester after the one just granted.
    always_comb begin
        nxt = {1'b0, grant_id} + (ID_W+1)'(1);
        if (nxt >= (ID_W+1)'(NUM_REQ)) begin
            nxt = '0;
        end
    end

    // Pointer register; holds when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= ID_W'(nxt);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory BRAM port arbiter: round-robin grant, memory mux, fixed-latency response pipeline.
// Optional statistics counters enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
`ifdef DMEM_ARB_STATS_EN
    input  logic                  stat_clear_in,
    output logic [NUM_REQ*32-1:0] stat_grants_out,
    output logic [31:0]           stat_conflicts_out,
`endif
    input  logic [NUM_REQ-1:0]    req_valid_in,
    output logic [NUM_REQ-1:0]    req_ready_out,
    input  logic [NUM_REQ*32-1:0] req_addr_in,
    input  logic [NUM_REQ*32-1:0] req_wdata_in,
    input  logic [NUM_REQ*4-1:0]  req_wstrb_in,
    output logic [NUM_REQ-1:0]    rsp_valid_out,
    output logic [31:0]           rsp_rdata_out,
    output logic [ADDR_W-1:0]     mem_addr_out,
    output logic [31:0]           mem_din_out,
    output logic [3:0]            mem_we_out,
    input  logic [31:0]           mem_dout_in
);

    logic [NUM_REQ-1:0] valid_g;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    mem_req_t           req [NUM_REQ];
    mem_req_t           sel;
    logic [ADDR_W-1:0]  last_addr;
    logic [31:0]        last_din;
    rsp_tag_t           stage [READ_LATENCY];
    logic               unused_addr;

    // No request can be granted while reset is held.
    assign valid_g = req_valid_in & {NUM_REQ{rst_n_in}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .valid     (valid_g),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign req_ready_out = grant;

    // Unpack the flat request buses into per-requester payloads.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req[i].addr  = req_addr_in[32*i +: 32];
            req[i].wdata = req_wdata_in[32*i +: 32];
            req[i].wstrb = req_wstrb_in[4*i +: 4];
        end
    end

    // Select the granted payload; all-zero when idle so the write strobe drops.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel = req[i];
            end
        end
    end

    // Byte offset and bits above the BRAM depth are ignored: addresses alias.
    assign unused_addr = ^sel.addr;

    // Remember the last driven address/data so the port holds when idle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_addr <= '0;
            last_din  <= '0;
        end else if (grant_any) begin
            last_addr <= sel.addr[ADDR_W+OFS_W-1:OFS_W];
            last_din  <= sel.wdata;
        end
    end

    assign mem_addr_out = grant_any ? sel.addr[ADDR_W+OFS_W-1:OFS_W] : last_addr;
    assign mem_din_out  = grant_any ? sel.wdata : last_din;
    assign mem_we_out   = sel.wstrb;

    // Owner-tag shift register aligned with the BRAM read latency.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= '{valid: grant_any, id: grant_id};
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    // Decode the last stage into a one-hot response pulse.
    always_comb begin
        rsp_valid_out = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid_out[i] = stage[READ_LATENCY-1].valid
                               && (stage[READ_LATENCY-1].id == ID_W'(i));
        end
    end

    assign rsp_rdata_out = mem_dout_in;

`ifdef DMEM_ARB_STATS_EN
    logic        multi_valid;
    logic [31:0] conflicts;

    assign multi_valid = (valid_g & (valid_g - NUM_REQ'(1))) != '0;

    // Saturating count of cycles with contention.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            conflicts <= '0;
        end else if (stat_clear_in) begin
            conflicts <= '0;
        end else if (multi_valid && (conflicts != 32'hFFFF_FFFF)) begin
            conflicts <= conflicts + 32'd1;
        end
    end

    assign stat_conflicts_out = conflicts;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        logic [31:0] grants;

        // Saturating per-requester accept count.
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                grants <= '0;
            end else if (stat_clear_in) begin
                grants <= '0;
            end else if (grant[gi] && (grants != 32'hFFFF_FFFF)) begin
                grants <= grants + 32'd1;
            end
        end

        assign stat_grants_out[32*gi +: 32] = grants;
    end
`endif

endmodule
